// File: rtl/ysyx_23060278_rf_pkg.sv
// Shared constants and helpers for the NPC register file with write scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_23060278_rf_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int NRD_DEF  = 2;
   localparam int CW_DEF   = 2;

   // Largest outstanding-write count a CW_DEF-bit counter can hold.
   localparam int CNT_MAX  = (1 << CW_DEF) - 1;

   // Register address width; a one-entry file still gets a 1-bit address.
   function automatic int calc_aw(input int nreg);
      return (nreg <= 1) ? 1 : $clog2(nreg);
   endfunction

endpackage

// File: rtl/ysyx_23060278_sb_cnt.sv
// Saturating up/down outstanding-write counter for one register, with clear.
// Latency: count updates one edge after inc/dec/clr; zero/one/full decode the current count.
// Backpressure: inc is ignored when full, dec is ignored when zero; clr wins over both.
// Ports: clk, rst (async active-low), inc, dec, clr -> cnt, zero, one, full.
module ysyx_23060278_sb_cnt #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          zero,
   output logic          one,
   output logic          full
);

   localparam logic [CW-1:0] L_CNT_MAX = {CW{1'b1}};

   logic [CW-1:0] r_cnt;
   logic          w_up;
   logic          w_dn;

   // Guards keep the count from wrapping in either direction.
   assign w_up = inc & ~full;
   assign w_dn = dec & ~zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (w_up && !w_dn) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (w_dn && !w_up) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign cnt  = r_cnt;
   assign zero = (r_cnt == '0);
   assign one  = (r_cnt == CW'(1));
   assign full = (r_cnt == L_CNT_MAX);

endmodule

// File: rtl/ysyx_23060278_regfile_sb.sv
// Parametrised integer register file with write-to-read bypass and per-register write scoreboard.
// Latency: reads combinational (bypass from WB in the same cycle); writes/counters/wb_err after one edge.
// Backpressure: issue_ready drops when the destination's outstanding-write counter is saturated.
// Ports: rs_addr/rs_data/rs_ready (NRD read ports), issue_valid/issue_rd/issue_ready (ID reservation),
//        wb_valid/wb_rd/wb_data (WB return), flush (drop all reservations), wb_err (sticky unexpected WB).
module ysyx_23060278_regfile_sb
   import ysyx_23060278_rf_pkg::*;
#(
   parameter  int XLEN     = XLEN_DEF,
   parameter  int NREG     = NREG_DEF,
   parameter  int NRD      = NRD_DEF,
   parameter  int CW       = CW_DEF,
   parameter  int ZERO_REG = 1,
   localparam int AW       = calc_aw(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]    rs_ready,
   input  logic              issue_valid,
   input  logic [AW-1:0]     issue_rd,
   output logic              issue_ready,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              wb_err
);

   logic [XLEN-1:0] r_regs [NREG];
   logic            r_wb_err;

   logic [CW-1:0]   w_cnt  [NREG];
   logic [NREG-1:0] w_zero;
   logic [NREG-1:0] w_one;
   logic [NREG-1:0] w_full;

   logic            w_wb_vld;
   logic            w_wb_en;
   logic            w_iss_en;

   // A writeback strobe seen while reset is held is ignored, so reads stay 0 during reset.
   assign w_wb_vld = wb_valid & rst;

   // x0 (when hardwired) swallows writebacks and issues without touching any state.
   assign w_wb_en  = w_wb_vld & ~((ZERO_REG != 0) && (wb_rd == '0));
   assign w_iss_en = issue_valid & issue_ready & ~((ZERO_REG != 0) && (issue_rd == '0));

   assign issue_ready = ~w_full[issue_rd];

   for (genvar g = 0; g < NREG; g++) begin : g_cnt
      ysyx_23060278_sb_cnt #(
         .CW (CW)
      ) u_cnt (
         .clk  (clk),
         .rst  (rst),
         .inc  (w_iss_en && (issue_rd == AW'(g))),
         .dec  (w_wb_en && (wb_rd == AW'(g))),
         .clr  (flush),
         .cnt  (w_cnt[g]),
         .zero (w_zero[g]),
         .one  (w_one[g]),
         .full (w_full[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NREG; k++) begin
            r_regs[k] <= '0;
         end
      end else if (w_wb_en) begin
         r_regs[wb_rd] <= wb_data;
      end
   end

   // A flush in the same cycle legitimately orphans the writeback, so it is not flagged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_err <= 1'b0;
      end else if (w_wb_en && !flush && (w_cnt[wb_rd] == '0)) begin
         r_wb_err <= 1'b1;
      end
   end

   assign wb_err = r_wb_err;

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_x0;
      logic          w_hit;

      assign w_ra  = rs_addr[gi*AW +: AW];
      assign w_x0  = (ZERO_REG != 0) && (w_ra == '0);
      assign w_hit = w_wb_vld && (wb_rd == w_ra);

      assign rs_data[gi*XLEN +: XLEN] = w_x0  ? '0 :
                                        w_hit ? wb_data : r_regs[w_ra];

      // Final when nothing is pending, or the only pending writer is returning right now.
      assign rs_ready[gi] = w_x0 | w_zero[w_ra] | (w_hit & w_one[w_ra]);
   end

endmodule

// File: tb/tb_ysyx_23060278_regfile_sb.sv
module tb_ysyx_23060278_regfile_sb;
   import ysyx_23060278_rf_pkg::*;

   localparam int AW = 5;

   logic          clk;
   logic          rst;
   logic [2*AW-1:0] rs_addr;
   logic [63:0]   rs_data;
   logic [1:0]    rs_ready;
   logic          issue_valid;
   logic [AW-1:0] issue_rd;
   logic          issue_ready;
   logic          wb_valid;
   logic [AW-1:0] wb_rd;
   logic [31:0]   wb_data;
   logic          flush;
   logic          wb_err;

   int n_chk;
   int n_err;

   ysyx_23060278_regfile_sb dut (
      .clk         (clk),
      .rst         (rst),
      .rs_addr     (rs_addr),
      .rs_data     (rs_data),
      .rs_ready    (rs_ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .flush       (flush),
      .wb_err      (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rs_addr = {a1, a0};
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      wb_valid    = 1'b0;
      flush       = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b0;
      idle();
      issue_rd = '0;
      wb_rd    = 5'd5;
      wb_data  = 32'h1234_5678;
      wb_valid = 1'b1;
      set_rs(5'd5, 5'd3);
      settle();

      // Reset state, with a writeback to x5 held during reset.
      chk("rst_rd0", rs_data[31:0], 32'h0);
      chk("rst_rd1", rs_data[63:32], 32'h0);
      chk("rst_rdy", {30'd0, rs_ready}, 32'h3);
      chk("rst_iss_rdy", {31'd0, issue_ready}, 32'h1);
      chk("rst_err", {31'd0, wb_err}, 32'h0);
      step();
      step();
      rst = 1'b1;
      wb_valid = 1'b0;
      settle();
      chk("post_rst_x5", rs_data[31:0], 32'h0);

      // Reserve x3, then write it: bypass in the same cycle, array afterwards.
      step();
      issue_valid = 1'b1; issue_rd = 5'd3;
      step();
      idle();
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
      set_rs(5'd3, 5'd0);
      settle();
      chk("byp_x3", rs_data[31:0], 32'hDEAD_BEEF);
      chk("byp_x3_rdy", {31'd0, rs_ready[0]}, 32'h1);
      step();
      idle();
      settle();
      chk("arr_x3", rs_data[31:0], 32'hDEAD_BEEF);

      // Writeback to x0 reads as zero and raises no error.
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h5555_5555;
      settle();
      chk("x0_byp", rs_data[63:32], 32'h0);
      step();
      idle();
      settle();
      chk("x0_arr", rs_data[63:32], 32'h0);
      chk("x0_no_err", {31'd0, wb_err}, 32'h0);

      // RAW on x7.
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      idle();
      set_rs(5'd7, 5'd3);
      settle();
      chk("raw_busy", {31'd0, rs_ready[0]}, 32'h0);
      chk("raw_other_rdy", {31'd0, rs_ready[1]}, 32'h1);
      step();
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5_0007;
      settle();
      chk("raw_wb_rdy", {31'd0, rs_ready[0]}, 32'h1);
      chk("raw_wb_dat", rs_data[31:0], 32'hA5A5_0007);
      step();
      idle();
      settle();
      chk("raw_done_rdy", {31'd0, rs_ready[0]}, 32'h1);
      chk("raw_done_dat", rs_data[31:0], 32'hA5A5_0007);

      // Saturation on x9: CNT_MAX issues accepted, the next one refused.
      issue_rd = 5'd9;
      for (int i = 0; i < CNT_MAX; i++) begin
         issue_valid = 1'b1;
         settle();
         chk("sat_iss_rdy", {31'd0, issue_ready}, 32'h1);
         step();
      end
      idle();
      settle();
      chk("sat_full", {31'd0, issue_ready}, 32'h0);
      issue_valid = 1'b1;
      step();
      idle();
      settle();
      chk("sat_still_full", {31'd0, issue_ready}, 32'h0);
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0009;
      step();
      idle();
      settle();
      chk("sat_freed", {31'd0, issue_ready}, 32'h1);
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0019;
      step();
      idle();
      set_rs(5'd9, 5'd3);
      settle();
      chk("sat_one_left", {31'd0, rs_ready[0]}, 32'h0);
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0029;
      settle();
      chk("sat_last_wb_rdy", {31'd0, rs_ready[0]}, 32'h1);
      step();
      idle();
      settle();
      chk("sat_drained", {31'd0, rs_ready[0]}, 32'h1);
      chk("sat_no_err", {31'd0, wb_err}, 32'h0);

      // Same-cycle issue + writeback on x4 with one outstanding.
      issue_valid = 1'b1; issue_rd = 5'd4;
      step();
      set_rs(5'd4, 5'd3);
      wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_0044;
      settle();
      chk("iw_rdy", {31'd0, rs_ready[0]}, 32'h1);
      chk("iw_dat", rs_data[31:0], 32'h0000_0044);
      step();
      idle();
      settle();
      chk("iw_cnt_kept", {31'd0, rs_ready[0]}, 32'h0);
      wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_0045;
      step();
      idle();
      settle();
      chk("iw_cleared", {31'd0, rs_ready[0]}, 32'h1);
      chk("iw_no_err", {31'd0, wb_err}, 32'h0);

      // Spurious writeback to x12.
      wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'h0000_C0C0;
      settle();
      chk("spur_err_not_yet", {31'd0, wb_err}, 32'h0);
      step();
      idle();
      set_rs(5'd12, 5'd3);
      settle();
      chk("spur_err", {31'd0, wb_err}, 32'h1);
      chk("spur_dat", rs_data[31:0], 32'h0000_C0C0);
      step();
      settle();
      chk("spur_sticky", {31'd0, wb_err}, 32'h1);

      // Flush drops reservations on x2/x6 and the concurrent issue of x8.
      issue_valid = 1'b1; issue_rd = 5'd2;
      step();
      issue_rd = 5'd6;
      step();
      idle();
      set_rs(5'd2, 5'd6);
      settle();
      chk("fl_busy", {30'd0, rs_ready}, 32'h0);
      flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8;
      step();
      idle();
      settle();
      chk("fl_cleared", {30'd0, rs_ready}, 32'h3);
      set_rs(5'd8, 5'd3);
      settle();
      chk("fl_x8_free", {31'd0, rs_ready[0]}, 32'h1);
      chk("fl_err_kept", {31'd0, wb_err}, 32'h1);

      // Asynchronous reset mid-operation clears the sticky flag and data.
      #1;
      rst = 1'b0;
      #1;
      set_rs(5'd3, 5'd12);
      settle();
      chk("arst_err", {31'd0, wb_err}, 32'h0);
      chk("arst_x3", rs_data[31:0], 32'h0);
      chk("arst_x12", rs_data[63:32], 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
